// File: rtl/clkgen_pkg.sv
// Shared types for the divider bank: FSM states, per-channel configuration
// record and its reset default.
package clkgen_pkg;

  localparam int CH_CNT_W = 9;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SETTLE
  } state_t;

  typedef struct packed {
    logic [CH_CNT_W-1:0] hi;
    logic [CH_CNT_W-1:0] lo;
    logic [CH_CNT_W-1:0] prst;
    logic                bypass;
    logic                en;
  } ch_cfg_t;

  localparam ch_cfg_t CH_CFG_RST = '{
    hi:     CH_CNT_W'(1),
    lo:     CH_CNT_W'(1),
    prst:   '0,
    bypass: 1'b0,
    en:     1'b0
  };

endpackage

// File: rtl/clkgen_div_ch.sv
// One hi/lo divider channel: a wrap-around phase counter with preset, producing
// a registered divided clock and a strobe at each of its rising edges.
module clkgen_div_ch
  import clkgen_pkg::*;
(
  input  logic    refclk,
  input  logic    rst,
  input  logic    load,
  input  ch_cfg_t cfg,
  output logic    outclk,
  output logic    outclk_en
);

  localparam int P_W = CH_CNT_W + 1;

  logic [CH_CNT_W-1:0] hi_e;
  logic [CH_CNT_W-1:0] lo_e;
  logic [P_W-1:0]      period;
  logic [P_W-1:0]      preset_e;
  logic [P_W-1:0]      cnt;
  logic [P_W-1:0]      cnt_next;

  // Zero-length phases are clamped to one cycle so the period is never < 2.
  assign hi_e     = (cfg.hi == '0) ? CH_CNT_W'(1) : cfg.hi;
  assign lo_e     = (cfg.lo == '0) ? CH_CNT_W'(1) : cfg.lo;
  assign period   = {1'b0, hi_e} + {1'b0, lo_e};
  assign preset_e = ({1'b0, cfg.prst} < period) ? {1'b0, cfg.prst} : '0;

  always_comb begin
    cnt_next = cnt;
    if (load || !cfg.en) begin
      cnt_next = preset_e;
    end else if (!cfg.bypass) begin
      cnt_next = (cnt >= period - 1'b1) ? '0 : cnt + 1'b1;
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      cnt       <= '0;
      outclk    <= 1'b0;
      outclk_en <= 1'b0;
    end else begin
      cnt       <= cnt_next;
      outclk    <= cfg.en & (cfg.bypass | (cnt_next < {1'b0, hi_e}));
      outclk_en <= cfg.en & (cfg.bypass | (cnt_next == '0));
    end
  end

endmodule

// File: rtl/clkgen_div_bank.sv
// Bank of run-time reconfigurable clock-enable dividers with shadow/active
// configuration, a write/apply handshake and a settle/lock indication.
module clkgen_div_bank
  import clkgen_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = CH_CNT_W,
  parameter int LOCK_CYCLES = 1024
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [3:0]        cfg_ch,
  input  logic [CNT_W-1:0]  cfg_hi,
  input  logic [CNT_W-1:0]  cfg_lo,
  input  logic [CNT_W-1:0]  cfg_prst,
  input  logic              cfg_bypass,
  input  logic              cfg_en,
  input  logic              cfg_apply,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] outclk,
  output logic [NUM_CH-1:0] outclk_en,
  output logic              locked,
  output logic              busy,
  output state_t            fsm_state
);

  localparam int SET_W = $clog2(LOCK_CYCLES + 1);

  // cfg_valid/cfg_ready: a write is taken on any edge where both are high;
  // cfg_ready is high only while the FSM is IDLE, and cfg_valid may be held
  // across non-IDLE cycles until that happens.
  state_t           state;
  state_t           state_next;
  logic [SET_W-1:0] settle_cnt;
  logic             settle_done;
  logic             write_ok;
  logic             ch_ok;
  logic             load;
  ch_cfg_t          shadow [NUM_CH];
  ch_cfg_t          active [NUM_CH];
  ch_cfg_t          ch_cfg [NUM_CH];

  assign fsm_state   = state;
  assign load        = (state == LOAD);
  assign write_ok    = cfg_valid && (state == IDLE);
  assign ch_ok       = ({1'b0, cfg_ch} < 5'(NUM_CH));
  assign settle_done = (state == SETTLE) && (settle_cnt == SET_W'(LOCK_CYCLES - 1));

  always_ff @(posedge refclk) begin
    if (rst) state <= SETTLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cfg_apply) state_next = LOAD;
      LOAD:    state_next = SETTLE;
      SETTLE:  if (settle_done) state_next = IDLE;
      default: state_next = SETTLE;
    endcase
  end

  // locked drops on the edge that accepts apply, so it is low during LOAD.
  always_ff @(posedge refclk) begin
    if (rst) begin
      settle_cnt <= '0;
      locked     <= 1'b0;
      busy       <= 1'b1;
      cfg_ready  <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      settle_cnt <= (state == SETTLE && !settle_done) ? settle_cnt + 1'b1 : '0;
      busy       <= (state_next != IDLE);
      cfg_ready  <= (state_next == IDLE);
      cfg_err    <= write_ok && !ch_ok;
      if (state_next == LOAD) locked <= 1'b0;
      else if (settle_done)   locked <= 1'b1;
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow[i] <= CH_CFG_RST;
        active[i] <= CH_CFG_RST;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (write_ok && cfg_ch == 4'(i)) begin
          shadow[i] <= '{hi: cfg_hi, lo: cfg_lo, prst: cfg_prst,
                         bypass: cfg_bypass, en: cfg_en};
        end
        if (load) active[i] <= shadow[i];
      end
    end
  end

  // During LOAD the channels see the shadow values so their counters preset
  // on the same edge that copies shadow into active.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ch_cfg[i] = load ? shadow[i] : active[i];
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clkgen_div_ch u_ch (
      .refclk    (refclk),
      .rst       (rst),
      .load      (load),
      .cfg       (ch_cfg[g]),
      .outclk    (outclk[g]),
      .outclk_en (outclk_en[g])
    );
  end

endmodule

// File: tb/tb_clkgen_div_bank.sv
// Directed test of clkgen_div_bank: expectations are queued per cycle and a
// negedge monitor compares them against the outputs.
module tb_clkgen_div_bank;
  import clkgen_pkg::*;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 9;
  localparam int LOCK   = 16;

  localparam int S_LOCKED = 8;
  localparam int S_READY  = 9;
  localparam int S_BUSY   = 10;
  localparam int S_ERR    = 11;

  logic              refclk     = 1'b0;
  logic              rst        = 1'b1;
  logic              cfg_valid  = 1'b0;
  logic              cfg_ready;
  logic [3:0]        cfg_ch     = '0;
  logic [CNT_W-1:0]  cfg_hi     = '0;
  logic [CNT_W-1:0]  cfg_lo     = '0;
  logic [CNT_W-1:0]  cfg_prst   = '0;
  logic              cfg_bypass = 1'b0;
  logic              cfg_en     = 1'b0;
  logic              cfg_apply  = 1'b0;
  logic              cfg_err;
  logic [NUM_CH-1:0] outclk;
  logic [NUM_CH-1:0] outclk_en;
  logic              locked;
  logic              busy;
  state_t            fsm_state;

  // entry: [31:12] cycle, [11:8] signal id, [0] expected value
  logic [31:0] exp_q[$];
  int cyc    = 0;
  int checks = 0;
  int passes = 0;

  clkgen_div_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .LOCK_CYCLES(LOCK)) dut (
    .refclk     (refclk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_hi     (cfg_hi),
    .cfg_lo     (cfg_lo),
    .cfg_prst   (cfg_prst),
    .cfg_bypass (cfg_bypass),
    .cfg_en     (cfg_en),
    .cfg_apply  (cfg_apply),
    .cfg_err    (cfg_err),
    .outclk     (outclk),
    .outclk_en  (outclk_en),
    .locked     (locked),
    .busy       (busy),
    .fsm_state  (fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 refclk = ~refclk;
  always @(posedge refclk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic goto_cyc(input int n);
    while (cyc < n) @(negedge refclk);
  endtask

  task automatic write_cfg(input logic [3:0] ch, input int hi, input int lo,
                           input int prst, input logic byp, input logic en,
                           input logic apply);
    cfg_valid  = 1'b1;
    cfg_ch     = ch;
    cfg_hi     = CNT_W'(hi);
    cfg_lo     = CNT_W'(lo);
    cfg_prst   = CNT_W'(prst);
    cfg_bypass = byp;
    cfg_en     = en;
    cfg_apply  = apply;
    @(negedge refclk);
    cfg_valid  = 1'b0;
    cfg_apply  = 1'b0;
  endtask

  task automatic do_apply();
    cfg_apply = 1'b1;
    @(negedge refclk);
    cfg_apply = 1'b0;
  endtask

  // ---------------- expectation helpers ----------------
  task automatic expect_at(input int c, input int s, input logic v);
    exp_q.push_back({c[19:0], s[3:0], 7'd0, v});
  endtask

  // pat is read MSB-first over n cycles, repeated reps times
  task automatic push_pattern(input int start, input int s, input int n,
                              input logic [15:0] pat, input int reps);
    for (int k = 0; k < n * reps; k++) expect_at(start + k, s, pat[n - 1 - (k % n)]);
  endtask

  // apply high in cycle t: LOAD at t+1, locked low t+1..t+17, high at t+18
  task automatic expect_lock_seq(input int t);
    expect_at(t + 1,  S_LOCKED, 1'b0);
    expect_at(t + 1,  S_BUSY,   1'b1);
    expect_at(t + 1,  S_READY,  1'b0);
    expect_at(t + 17, S_LOCKED, 1'b0);
    expect_at(t + 18, S_LOCKED, 1'b1);
    expect_at(t + 18, S_READY,  1'b1);
    expect_at(t + 18, S_BUSY,   1'b0);
  endtask

  task automatic check_state(input state_t exp_s);
    checks++;
    if (fsm_state === exp_s) passes++;
    else $display("FAIL fsm_state cycle %0d: got %s expected %s", cyc,
                  fsm_state.name(), exp_s.name());
  endtask

  // ---------------- scoreboard monitor ----------------
  function automatic logic sample(input int s);
    logic [3:0] si;
    si = s[3:0];
    case (si)
      4'd0, 4'd1, 4'd2, 4'd3: return outclk[si[1:0]];
      4'd4, 4'd5, 4'd6, 4'd7: return outclk_en[si[1:0]];
      4'd8:    return locked;
      4'd9:    return cfg_ready;
      4'd10:   return busy;
      default: return cfg_err;
    endcase
  endfunction

  function automatic string sig_name(input int s);
    if (s < 4)        return $sformatf("outclk[%0d]", s);
    else if (s < 8)   return $sformatf("outclk_en[%0d]", s - 4);
    else if (s == 8)  return "locked";
    else if (s == 9)  return "cfg_ready";
    else if (s == 10) return "busy";
    else              return "cfg_err";
  endfunction

  always @(negedge refclk) begin
    int   s;
    logic e;
    logic a;
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (int'(exp_q[i][31:12]) == cyc) begin
        s = int'(exp_q[i][11:8]);
        e = exp_q[i][0];
        a = sample(s);
        checks++;
        if (a === e) passes++;
        else $display("FAIL %s cycle %0d: got %b expected %b", sig_name(s), cyc, a, e);
        exp_q.delete(i);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // reset: rst high for edges 1..3, SETTLE entry at cycle 3, lock at 19
    for (int s = 0; s < 8; s++) expect_at(2, s, 1'b0);
    expect_at(2,  S_LOCKED, 1'b0);
    expect_at(2,  S_ERR,    1'b0);
    expect_at(2,  S_BUSY,   1'b1);
    expect_at(2,  S_READY,  1'b0);
    expect_at(18, S_LOCKED, 1'b0);
    expect_at(18, S_READY,  1'b0);
    expect_at(19, S_LOCKED, 1'b1);
    expect_at(19, S_READY,  1'b1);
    expect_at(19, S_BUSY,   1'b0);
    goto_cyc(3);
    rst = 1'b0;

    // basic divide by 4 on ch0
    goto_cyc(20);
    check_state(IDLE);
    write_cfg(4'd0, 2, 2, 0, 1'b0, 1'b1, 1'b0);
    expect_lock_seq(cyc);
    push_pattern(cyc + 2, 0, 4, 16'b1100, 3);
    push_pattern(cyc + 2, 4, 4, 16'b1000, 3);
    push_pattern(cyc + 2, 1, 1, 16'b0, 4);
    do_apply();

    // phase preset: ch2 leads ch1 by two cycles, ch0 realigned
    goto_cyc(40);
    write_cfg(4'd1, 3, 2, 0, 1'b0, 1'b1, 1'b0);
    write_cfg(4'd2, 3, 2, 2, 1'b0, 1'b1, 1'b0);
    expect_lock_seq(cyc);
    push_pattern(cyc + 2, 1, 5, 16'b11100, 2);
    push_pattern(cyc + 2, 2, 5, 16'b10011, 2);
    push_pattern(cyc + 2, 5, 5, 16'b10000, 2);
    push_pattern(cyc + 2, 6, 5, 16'b00010, 2);
    push_pattern(cyc + 2, 0, 4, 16'b1100, 2);
    do_apply();

    // bypass on ch3, hi/lo/prst ignored
    goto_cyc(61);
    write_cfg(4'd3, 5, 7, 3, 1'b1, 1'b1, 1'b0);
    expect_lock_seq(cyc);
    push_pattern(cyc + 2, 3, 1, 16'b1, 8);
    push_pattern(cyc + 2, 7, 1, 16'b1, 8);
    do_apply();

    // write+apply in the same cycle, hi=lo=0 clamps to period 2
    goto_cyc(81);
    expect_lock_seq(cyc);
    push_pattern(cyc + 2, 3, 2, 16'b10, 4);
    push_pattern(cyc + 2, 7, 2, 16'b10, 4);
    write_cfg(4'd3, 0, 0, 0, 1'b0, 1'b1, 1'b1);

    // out-of-range channel: error pulse, no shadow change
    goto_cyc(100);
    expect_at(101, S_ERR, 1'b1);
    expect_at(102, S_ERR, 1'b0);
    write_cfg(4'd7, 1, 5, 0, 1'b0, 1'b1, 1'b0);
    goto_cyc(102);
    expect_lock_seq(cyc);
    push_pattern(cyc + 2, 0, 4, 16'b1100, 2);
    push_pattern(cyc + 2, 1, 5, 16'b11100, 2);
    push_pattern(cyc + 2, 3, 2, 16'b10, 4);
    do_apply();

    // valid held through SETTLE is not taken; apply in SETTLE is ignored
    goto_cyc(104);
    cfg_valid  = 1'b1;
    cfg_ch     = 4'd9;
    cfg_hi     = CNT_W'(4);
    cfg_lo     = CNT_W'(4);
    cfg_prst   = '0;
    cfg_bypass = 1'b0;
    cfg_en     = 1'b1;
    push_pattern(105, S_ERR, 1, 16'b0, 6);
    expect_at(119, S_READY, 1'b0);
    expect_at(120, S_READY, 1'b1);
    expect_at(121, S_READY, 1'b1);
    goto_cyc(106);
    cfg_apply = 1'b1;
    goto_cyc(107);
    cfg_apply = 1'b0;
    goto_cyc(110);
    cfg_ch = 4'd0;
    cfg_hi = CNT_W'(1);
    cfg_lo = CNT_W'(3);
    goto_cyc(121);
    cfg_valid = 1'b0;
    expect_lock_seq(cyc);
    push_pattern(cyc + 2, 0, 4, 16'b1000, 3);
    push_pattern(cyc + 2, 3, 2, 16'b10, 3);
    do_apply();

    // reset five cycles into SETTLE
    goto_cyc(140);
    expect_at(141, S_LOCKED, 1'b0);
    expect_at(141, S_BUSY,   1'b1);
    push_pattern(142, 0, 5, 16'b10001, 1);
    push_pattern(142, 3, 5, 16'b10101, 1);
    for (int s = 0; s < 8; s++) push_pattern(147, s, 1, 16'b0, 6);
    expect_at(147, S_LOCKED, 1'b0);
    expect_at(147, S_BUSY,   1'b1);
    expect_at(147, S_READY,  1'b0);
    expect_at(162, S_LOCKED, 1'b0);
    expect_at(163, S_LOCKED, 1'b1);
    expect_at(163, S_READY,  1'b1);
    do_apply();
    goto_cyc(146);
    rst = 1'b1;
    goto_cyc(147);
    rst = 1'b0;

    // shadow registers were reset too: apply leaves every channel disabled
    goto_cyc(164);
    expect_lock_seq(cyc);
    for (int s = 0; s < 8; s++) push_pattern(cyc + 2, s, 1, 16'b0, 6);
    do_apply();

    // ---------------- final report ----------------
    goto_cyc(195);
    check_state(IDLE);
    if (exp_q.size() != 0)
      $display("FAIL %0d expectations left in queue", exp_q.size());
    foreach (exp_q[i]) begin
      checks++;
      $display("FAIL %s cycle %0d: expectation never compared", sig_name(int'(exp_q[i][11:8])),
               int'(exp_q[i][31:12]));
    end
    if (passes != checks) $display("FAIL %0d checks failed", checks - passes);
    else                  $display("PASS all checks");
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
